// File: rtl/decoded_instr_queue.sv
// Decoded-instruction FIFO between decode and issue. Wrap-bit pointers give full/empty
// without a spare slot; flush or reset empties the queue in one cycle.
package ctrl_sigs;
    typedef enum logic [3:0] {
        UOP_NOP, UOP_ADDI, UOP_ADD, UOP_LW, UOP_SW, UOP_BEQ, UOP_JAL
    } uop_e;

    typedef struct packed {
        uop_e        uopcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        taken;
        logic        shadowed;
    } queue_item_t;
endpackage

module decoded_instr_queue
    import ctrl_sigs::*;
#(
    parameter  int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              enq_valid_i,
    output logic              enq_ready_o,
    input  queue_item_t       enq_item_i,
    input  logic [31:0]       enq_pc_i,
    output logic              deq_valid_o,
    input  logic              deq_ready_i,
    output queue_item_t       deq_item_o,
    output logic [31:0]       deq_pc_o,
    output logic [CNT_W-1:0]  count_o
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    queue_item_t mem_item_q [DEPTH];
    logic [31:0] mem_pc_q   [DEPTH];

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty, full, enq_fire, deq_fire;

    assign empty = (head_q == tail_q);
    assign full  = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) && (head_q[IDX_W] != tail_q[IDX_W]);

    // Ready/valid come from registered pointers only: no issue->decode comb path.
    assign enq_ready_o = !full;
    assign deq_valid_o = !empty;
    assign enq_fire    = enq_valid_i && enq_ready_o;
    assign deq_fire    = deq_valid_o && deq_ready_i;

    assign deq_item_o  = mem_item_q[head_q[IDX_W-1:0]];
    assign deq_pc_o    = mem_pc_q[head_q[IDX_W-1:0]];
    assign count_o     = count_q;

    always_comb begin
        head_d  = head_q + PTR_W'(deq_fire);
        tail_d  = tail_q + PTR_W'(enq_fire);
        count_d = count_q;
        case ({enq_fire, deq_fire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage has no reset; an enq coinciding with flush/reset is dropped.
    always_ff @(posedge clk_i) begin
        if (enq_fire && !rst_i && !flush_i) begin
            mem_item_q[tail_q[IDX_W-1:0]] <= enq_item_i;
            mem_pc_q[tail_q[IDX_W-1:0]]   <= enq_pc_i;
        end
    end

    a_count_ptr: assert property (@(posedge clk_i) disable iff (rst_i)
        count_q == CNT_W'(tail_q - head_q));
    a_count_max: assert property (@(posedge clk_i) disable iff (rst_i)
        count_q <= CNT_W'(DEPTH));
    a_empty_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (empty && deq_ready_i && !flush_i) |=> $stable(head_q));
endmodule

// File: tb/tb_decoded_instr_queue.sv
// Bench for decoded_instr_queue: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_decoded_instr_queue;
    import ctrl_sigs::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        queue_item_t item;
        logic [31:0] pc;
    } entry_t;

    logic             clk = 0;
    logic             rst = 1, flush = 0, enq_valid = 0, deq_ready = 0;
    queue_item_t      enq_item = '0;
    logic [31:0]      enq_pc = '0;
    logic             enq_ready, deq_valid;
    queue_item_t      deq_item;
    logic [31:0]      deq_pc;
    logic [CNT_W-1:0] count;

    int checks = 0, failures = 0;
    bit chk_en = 0;
    entry_t model [$];

    decoded_instr_queue #(.DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .enq_valid_i(enq_valid), .enq_ready_o(enq_ready),
        .enq_item_i(enq_item), .enq_pc_i(enq_pc),
        .deq_valid_o(deq_valid), .deq_ready_i(deq_ready),
        .deq_item_o(deq_item), .deq_pc_o(deq_pc), .count_o(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a FIFO of at most DEPTH entries, both handshakes judged on pre-edge occupancy.
    always @(posedge clk) begin
        if (rst || flush) begin
            model.delete();
        end else begin
            automatic bit do_deq = (model.size() != 0) && deq_ready;
            automatic bit do_enq = (model.size() < DEPTH) && enq_valid;
            if (do_deq) void'(model.pop_front());
            if (do_enq) model.push_back('{enq_item, enq_pc});
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("count", 64'(count), 64'(model.size()));
            chk("enq_ready", 64'(enq_ready), 64'(model.size() < DEPTH));
            chk("deq_valid", 64'(deq_valid), 64'(model.size() != 0));
            if (model.size() != 0) begin
                chk("deq_pc", 64'(deq_pc), 64'(model[0].pc));
                chk("deq_item", 64'(deq_item), 64'(model[0].item));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; flush = 0; enq_valid = 0; deq_ready = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        cyc();
        rst = 0;
    endtask

    function automatic queue_item_t mk_item(input uop_e op, input logic [4:0] rd, input logic [31:0] imm);
        queue_item_t it;
        it = '0;
        it.uopcode = op;
        it.rd = rd;
        it.imm = imm;
        return it;
    endfunction

    task automatic enq_one(input logic [31:0] pc);
        enq_valid = 1;
        enq_pc = pc;
        enq_item = mk_item(UOP_ADD, pc[6:2], pc);
        cyc();
        enq_valid = 0;
    endtask

    initial begin
        queue_item_t addi5;
        cyc();
        cyc();
        rst = 0;
        chk_en = 1;
        chk("rst_enq_ready", 64'(enq_ready), 64'd1);
        chk("rst_deq_valid", 64'(deq_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);

        // 1: single enq visible next cycle
        addi5 = mk_item(UOP_ADDI, 5'd5, 32'd0);
        enq_item = addi5;
        enq_pc = 32'h60;
        enq_valid = 1;
        chk("t1_pre_valid", 64'(deq_valid), 64'd0);
        cyc();
        enq_valid = 0;
        chk("t1_deq_valid", 64'(deq_valid), 64'd1);
        chk("t1_deq_pc", 64'(deq_pc), 64'h60);
        chk("t1_count", 64'(count), 64'd1);
        chk("t1_item", 64'(deq_item), 64'(addi5));

        // 2: fill, refuse 9th, free one slot
        do_reset();
        for (int i = 0; i < 8; i++) enq_one(32'h1000 + 32'(4 * i));
        chk("t2_full_ready", 64'(enq_ready), 64'd0);
        chk("t2_full_count", 64'(count), 64'd8);
        enq_one(32'hBAD0);
        chk("t2_9th_count", 64'(count), 64'd8);
        chk("t2_head_pc", 64'(deq_pc), 64'h1000);
        deq_ready = 1;
        cyc();
        deq_ready = 0;
        chk("t2_ready_again", 64'(enq_ready), 64'd1);
        chk("t2_count7", 64'(count), 64'd7);
        chk("t2_new_head", 64'(deq_pc), 64'h1004);
        deq_ready = 1;
        for (int i = 0; i < 7; i++) cyc();
        deq_ready = 0;
        chk("t2_drained", 64'(count), 64'd0);

        // 3: enq+deq every cycle across several pointer wraps
        do_reset();
        enq_one(32'h0);
        for (int k = 0; k < 20; k++) begin
            enq_valid = 1;
            deq_ready = 1;
            enq_pc = 32'(4 * (k + 1));
            enq_item = mk_item(UOP_LW, 5'(k), 32'(k));
            cyc();
            chk("t3_count", 64'(count), 64'd1);
            chk("t3_deq_pc", 64'(deq_pc), 64'(4 * (k + 1)));
        end
        idle();

        // 4: flush with simultaneous enq and deq
        do_reset();
        for (int i = 0; i < 5; i++) enq_one(32'h2000 + 32'(4 * i));
        chk("t4_count5", 64'(count), 64'd5);
        flush = 1;
        enq_valid = 1;
        deq_ready = 1;
        enq_pc = 32'hDEAD;
        cyc();
        idle();
        chk("t4_count", 64'(count), 64'd0);
        chk("t4_deq_valid", 64'(deq_valid), 64'd0);
        enq_one(32'h100);
        chk("t4_after_pc", 64'(deq_pc), 64'h100);
        chk("t4_after_count", 64'(count), 64'd1);

        // 5: reset mid-stream
        do_reset();
        for (int i = 0; i < 3; i++) enq_one(32'h3000 + 32'(4 * i));
        rst = 1;
        enq_valid = 1;
        deq_ready = 1;
        enq_pc = 32'hBEEF;
        cyc();
        idle();
        chk("t5_count", 64'(count), 64'd0);
        chk("t5_enq_ready", 64'(enq_ready), 64'd1);
        chk("t5_deq_valid", 64'(deq_valid), 64'd0);
        enq_one(32'h200);
        enq_one(32'h204);
        chk("t5_head", 64'(deq_pc), 64'h200);
        deq_ready = 1;
        cyc();
        chk("t5_second", 64'(deq_pc), 64'h204);
        cyc();
        idle();
        chk("t5_empty", 64'(deq_valid), 64'd0);

        // 6: random traffic against the model
        do_reset();
        for (int n = 0; n < 10000; n++) begin
            enq_valid = 1'($urandom_range(0, 1));
            deq_ready = 1'($urandom_range(0, 1));
            enq_pc = $urandom;
            enq_item.uopcode  = uop_e'($urandom_range(0, 6));
            enq_item.rd       = 5'($urandom);
            enq_item.rs1      = 5'($urandom);
            enq_item.rs2      = 5'($urandom);
            enq_item.imm      = $urandom;
            enq_item.taken    = 1'($urandom);
            enq_item.shadowed = 1'($urandom);
            cyc();
        end
        idle();
        deq_ready = 1;
        for (int i = 0; i < DEPTH + 1; i++) cyc();
        idle();
        chk("t6_drained", 64'(count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
